// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response and ALU signal bundle for alu_arbiter
// master = requesters + ALU side, slave = the arbiter itself.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        ReqValid;
  logic [NUM_REQ-1:0]        ReqReady;
  logic [NUM_REQ*DATA_W-1:0] ReqArg1;
  logic [NUM_REQ*DATA_W-1:0] ReqArg2;
  logic [NUM_REQ*4-1:0]      ReqOp;
  logic [NUM_REQ-1:0]        RspValid;
  logic [NUM_REQ-1:0]        RspReady;
  logic [DATA_W-1:0]         RspResult;
  logic [2:0]                RspGES;
  logic [DATA_W-1:0]         Arg1;
  logic [DATA_W-1:0]         Arg2;
  logic [3:0]                ALU_Control;
  logic [DATA_W-1:0]         ALUResult;
  logic [2:0]                GES;

  modport master (
    output ReqValid, ReqArg1, ReqArg2, ReqOp, RspReady, ALUResult, GES,
    input  ReqReady, RspValid, RspResult, RspGES, Arg1, Arg2, ALU_Control
  );

  modport slave (
    input  ReqValid, ReqArg1, ReqArg2, ReqOp, RspReady, ALUResult, GES,
    output ReqReady, RspValid, RspResult, RspGES, Arg1, Arg2, ALU_Control
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one combinational ALU between requesters
// Optional ALU_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [DATA_W-1:0]  arg1_q, arg1_d;
  logic [DATA_W-1:0]  arg2_q, arg2_d;
  logic [3:0]         op_q, op_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [2:0]         ges_q, ges_d;
  logic               is_cmp;
  logic               is_undef;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'(k);
      if (bus.ReqValid[cand_idx] && !any_req) begin
        winner  = cand_idx;
        any_req = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Search starts just after the last served requester and wraps around.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant_q) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (bus.ReqValid[cand_idx] && !any_req) begin
        winner  = cand_idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == RESP && bus.RspReady[grant_q]) begin
      last_grant_d = grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign is_cmp   = (op_q == 4'b1000) || (op_q == 4'b1001);
  assign is_undef = (op_q >= 4'b1010);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    arg1_d       = arg1_q;
    arg2_d       = arg2_q;
    op_d         = op_q;
    result_d     = result_q;
    ges_d        = ges_q;
    bus.ReqReady = '0;
    bus.RspValid = '0;
    unique case (state_q)
      IDLE: begin
        // rst_n gate keeps ReqReady low while reset is held with requests pending.
        if (any_req && rst_n) begin
          bus.ReqReady[winner] = 1'b1;
          grant_d              = winner;
          arg1_d               = bus.ReqArg1[int'(winner)*DATA_W +: DATA_W];
          arg2_d               = bus.ReqArg2[int'(winner)*DATA_W +: DATA_W];
          op_d                 = bus.ReqOp[int'(winner)*4 +: 4];
          state_d              = EXEC;
        end
      end
      EXEC: begin
        result_d = (is_cmp || is_undef) ? '0 : bus.ALUResult;
        ges_d    = is_cmp ? bus.GES : 3'b000;
        state_d  = RESP;
      end
      RESP: begin
        bus.RspValid[grant_q] = 1'b1;
        if (bus.RspReady[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      arg1_q   <= '0;
      arg2_q   <= '0;
      op_q     <= '0;
      result_q <= '0;
      ges_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      arg1_q   <= arg1_d;
      arg2_q   <= arg2_d;
      op_q     <= op_d;
      result_q <= result_d;
      ges_q    <= ges_d;
    end
  end

  assign bus.Arg1        = arg1_q;
  assign bus.Arg2        = arg2_q;
  assign bus.ALU_Control = op_q;
  assign bus.RspResult   = result_q;
  assign bus.RspGES      = ges_q;
endmodule
